// File: rtl/multiword_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// multiword_add_ctrl_if
//   Stream bundle for the word-serial multi-precision adder controller.
//   Operand side : in_valid / in_ready / in_last / a_word / b_word
//   Result side  : out_valid / out_ready / sum_word / out_last / word_idx /
//                  carry_out, plus the sticky len_err status flag.
//   Optional     : sub (only when MULTIWORD_ADD_CTRL_SUB_EN is defined).
//   Modports     : master = stream source/sink environment, slave = controller.
// ---------------------------------------------------------------------------
interface multiword_add_ctrl_if #(
   parameter int WIDTH     = 4,
   parameter int MAX_WORDS = 8,
   parameter int IDX_W     = $clog2(MAX_WORDS)
);
   logic             in_valid;
   logic             in_ready;
   logic             in_last;
   logic [WIDTH-1:0] a_word;
   logic [WIDTH-1:0] b_word;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum_word;
   logic             out_last;
   logic [IDX_W-1:0] word_idx;
   logic             carry_out;
   logic             len_err;
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
   logic             sub;
`endif

   modport master (
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
      output sub,
`endif
      output in_valid, in_last, a_word, b_word, out_ready,
      input  in_ready, out_valid, sum_word, out_last, word_idx, carry_out, len_err
   );

   modport slave (
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
      input  sub,
`endif
      input  in_valid, in_last, a_word, b_word, out_ready,
      output in_ready, out_valid, sum_word, out_last, word_idx, carry_out, len_err
   );
endinterface

// File: rtl/multiword_add_ctrl.sv
// ---------------------------------------------------------------------------
// multiword_add_ctrl
//   Word-serial multi-precision adder controller. One WIDTH-bit adder is
//   sequenced across operands of 1..MAX_WORDS words, LSW first, with the
//   inter-word carry kept in carry_reg. Each accepted operand pair produces
//   one registered sum word one cycle later; the last word also reports the
//   final carry. Operations longer than MAX_WORDS are cut at MAX_WORDS words
//   and flagged in the sticky len_err bit.
//
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - multiword_add_ctrl_if.slave (operand stream in, sum stream out)
//
//   Build option: MULTIWORD_ADD_CTRL_SUB_EN adds bus.sub; when set on the
//   first word of an operation the whole operation computes A - B
//   (B inverted, initial carry 1; carry_out=1 means no borrow).
// ---------------------------------------------------------------------------
module multiword_add_ctrl #(
   parameter int WIDTH     = 4,
   parameter int MAX_WORDS = 8,
   parameter int IDX_W     = $clog2(MAX_WORDS)
) (
   input logic                clk,
   input logic                rst_n,
   multiword_add_ctrl_if.slave bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]       state;
   logic [IDX_W-1:0] cnt;
   logic             carry_reg;

   logic             out_valid_q;
   logic [WIDTH-1:0] sum_word_q;
   logic             out_last_q;
   logic [IDX_W-1:0] word_idx_q;
   logic             carry_out_q;
   logic             len_err_q;

   logic             in_ready;
   logic             accept;
   logic             op_sub;
   logic             carry_in;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum_full;
   logic             at_limit;
   logic             last_eff;

   // Single output register: a new word may enter whenever the current one
   // is absent or leaving this cycle.
   assign in_ready = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;

`ifdef MULTIWORD_ADD_CTRL_SUB_EN
   logic sub_reg;

   // The mode is taken from the port only on the first word; later words use
   // the latched copy so mid-operation changes are ignored.
   assign op_sub = (state == ST_IDLE) ? bus.sub : sub_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sub_reg <= 1'b0;
      else if (accept && state == ST_IDLE)
         sub_reg <= bus.sub;
   end
`else
   assign op_sub = 1'b0;
`endif

   // First word of an operation injects the mode-dependent initial carry;
   // carry_reg is always 0 in IDLE so it only matters once BUSY.
   assign carry_in = (state == ST_IDLE) ? op_sub : carry_reg;
   assign b_eff    = op_sub ? ~bus.b_word : bus.b_word;
   assign sum_full = {1'b0, bus.a_word} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};

   // MAX_WORDS >= 2, so the limit can only be hit while BUSY.
   assign at_limit = (state == ST_BUSY) && (cnt == IDX_W'(MAX_WORDS - 1));
   assign last_eff = bus.in_last || at_limit;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         carry_reg   <= 1'b0;
         out_valid_q <= 1'b0;
         sum_word_q  <= '0;
         out_last_q  <= 1'b0;
         word_idx_q  <= '0;
         carry_out_q <= 1'b0;
         len_err_q   <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         sum_word_q  <= sum_full[WIDTH-1:0];
         word_idx_q  <= cnt;
         out_last_q  <= last_eff;
         if (last_eff) begin
            carry_out_q <= sum_full[WIDTH];
            carry_reg   <= 1'b0;
            cnt         <= '0;
            state       <= ST_IDLE;
            if (at_limit && !bus.in_last)
               len_err_q <= 1'b1;
         end else begin
            carry_reg <= sum_full[WIDTH];
            cnt       <= cnt + IDX_W'(1);
            state     <= ST_BUSY;
         end
      end else if (bus.out_ready) begin
         // Payload is left in place; only the valid flag drops.
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.sum_word  = sum_word_q;
   assign bus.out_last  = out_last_q;
   assign bus.word_idx  = word_idx_q;
   assign bus.carry_out = carry_out_q;
   assign bus.len_err   = len_err_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multiword_add_ctrl
//   Self-checking bench for multiword_add_ctrl (WIDTH=4, MAX_WORDS=8).
//   A reference model computes each expected sum word when its operand pair
//   is accepted and pushes it to a queue; a negedge monitor pops and compares
//   on every output transfer. Directed checks cover reset state, latency,
//   backpressure stability, length limit and reset mid-operation.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multiword_add_ctrl;

   localparam int WIDTH     = 4;
   localparam int MAX_WORDS = 8;
   localparam int IDX_W     = $clog2(MAX_WORDS);

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             last;
      logic [IDX_W-1:0] idx;
      logic             carry;
      logic             len_err;
   } exp_t;

   logic clk;
   logic rst_n;

   multiword_add_ctrl_if #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) bus ();

   multiword_add_ctrl #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   int   stall_cnt = 0;
   exp_t sb_q[$];

   // Reference model state
   bit       m_busy    = 0;
   int       m_cnt     = 0;
   bit       m_carry   = 0;
   bit       m_sub     = 0;
   bit       m_len_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic last, input logic sub);
      int   total;
      int   bb;
      bit   cin;
      bit   op_sub;
      bit   limit;
      exp_t e;
      if (!m_busy) begin
         m_sub = sub;
         cin   = sub;
      end else begin
         cin = m_carry;
      end
      op_sub = m_sub;
      bb     = op_sub ? ((~int'(b)) & 'hF) : int'(b);
      total  = int'(a) + bb + int'(cin);
      limit  = m_busy && (m_cnt == MAX_WORDS - 1) && !last;
      e.sum   = total[WIDTH-1:0];
      e.last  = last || limit;
      e.idx   = m_cnt[IDX_W-1:0];
      e.carry = total[WIDTH];
      if (limit) m_len_err = 1;
      e.len_err = m_len_err;
      sb_q.push_back(e);
      if (e.last) begin
         m_busy  = 0;
         m_cnt   = 0;
         m_carry = 0;
      end else begin
         m_busy  = 1;
         m_cnt   = m_cnt + 1;
         m_carry = total[WIDTH];
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_cnt = 0; m_carry = 0; m_sub = 0; m_len_err = 0;
      sb_q.delete();
   endtask

   // Drive one operand pair and wait (bounded) for its transfer.
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic last, input logic sub);
      bit acc;
      int waited;
      waited = 0;
      bus.in_valid = 1'b1;
      bus.a_word   = a;
      bus.b_word   = b;
      bus.in_last  = last;
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
      bus.sub      = sub;
`endif
      forever begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         if (acc) break;
         waited++;
         if (waited > 100) begin
            check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            #1 bus.in_valid = 1'b0;
            return;
         end
      end
      model_push(a, b, last, sub);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while ((sb_q.size() != 0 || bus.out_valid) && cyc < 50) begin
         @(posedge clk);
         cyc++;
      end
      check("drain_empty", 32'(sb_q.size()), 32'd0);
      #1;
   endtask

   // Scoreboard monitor: compares every output transfer.
   always @(negedge clk) begin
      if (rst_n && bus.in_valid && !bus.in_ready) stall_cnt++;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_output", 32'(bus.sum_word), 32'hDEAD);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sum_word", 32'(bus.sum_word), 32'(e.sum));
            check("out_last", 32'(bus.out_last), 32'(e.last));
            check("word_idx", 32'(bus.word_idx), 32'(e.idx));
            check("len_err",  32'(bus.len_err),  32'(e.len_err));
            if (e.last) check("carry_out", 32'(bus.carry_out), 32'(e.carry));
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] held_sum;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.a_word    = '0;
      bus.b_word    = '0;
      bus.out_ready = 1'b1;
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
      bus.sub       = 1'b0;
`endif
      #12;
      // Reset state
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_sum_word",  32'(bus.sum_word),  32'd0);
      check("rst_out_last",  32'(bus.out_last),  32'd0);
      check("rst_word_idx",  32'(bus.word_idx),  32'd0);
      check("rst_carry_out", 32'(bus.carry_out), 32'd0);
      check("rst_len_err",   32'(bus.len_err),   32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: single word 9+8, one-cycle latency
      send(4'h9, 4'h8, 1'b1, 1'b0);
      @(negedge clk);
      check("t1_valid", 32'(bus.out_valid), 32'd1);
      check("t1_sum",   32'(bus.sum_word),  32'h1);
      check("t1_carry", 32'(bus.carry_out), 32'd1);
      drain();

      // 2: 0xFF + 0x01
      send(4'hF, 4'h1, 1'b0, 1'b0);
      send(4'hF, 4'h0, 1'b1, 1'b0);
      drain();

      // 3: back-to-back, no stalls, carry must not leak
      stall_cnt = 0;
      send(4'h2, 4'h1, 1'b0, 1'b0);
      send(4'h3, 4'h1, 1'b1, 1'b0);
      send(4'h7, 4'h1, 1'b1, 1'b0);
      drain();
      check("t3_no_stall", 32'(stall_cnt), 32'd0);

      // 4: backpressure holds output stable and blocks input
      bus.out_ready = 1'b0;
      send(4'h5, 4'h6, 1'b0, 1'b0);
      @(negedge clk);
      held_sum = bus.sum_word;
      check("t4_first_sum", 32'(held_sum), 32'hB);
      for (int i = 0; i < 3; i++) begin
         check("t4_in_ready", 32'(bus.in_ready),  32'd0);
         check("t4_valid",    32'(bus.out_valid), 32'd1);
         check("t4_stable",   32'(bus.sum_word),  32'(held_sum));
         @(negedge clk);
      end
      @(posedge clk); #1 bus.out_ready = 1'b1;
      send(4'hA, 4'h3, 1'b1, 1'b0);
      drain();

      // 5: length limit, 9 words without in_last, then close the new op
      for (int i = 0; i < 9; i++) send(4'hF, 4'h1, 1'b0, 1'b0);
      send(4'h2, 4'h2, 1'b1, 1'b0);
      drain();
      check("t5_len_err_sticky", 32'(bus.len_err), 32'd1);

      // Random multi-word operations with full throughput
      for (int op = 0; op < 6; op++) begin
         int len;
         len = $urandom_range(1, 4);
         for (int w = 0; w < len; w++)
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), (w == len - 1), 1'b0);
      end
      drain();

      // 6: reset mid-operation discards the partial op
      send(4'h8, 4'h9, 1'b0, 1'b0);
      send(4'h8, 4'h9, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("t6_rst_valid",   32'(bus.out_valid), 32'd0);
      check("t6_rst_sum",     32'(bus.sum_word),  32'd0);
      check("t6_rst_len_err", 32'(bus.len_err),   32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      send(4'h1, 4'h1, 1'b1, 1'b0);
      @(negedge clk);
      check("t6_sum",   32'(bus.sum_word),  32'h2);
      check("t6_carry", 32'(bus.carry_out), 32'd0);
      drain();
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
      send(4'h3, 4'h5, 1'b1, 1'b1);
      @(negedge clk);
      check("t6_sub_sum",   32'(bus.sum_word),  32'hE);
      check("t6_sub_carry", 32'(bus.carry_out), 32'd0);
      drain();
      // Multi-word subtract with sub dropped mid-operation: 0x21 - 0x12 = 0x0F
      send(4'h1, 4'h2, 1'b0, 1'b1);
      send(4'h2, 4'h1, 1'b1, 1'b0);
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multiword_add_ctrl.md
Name: multiword_add_ctrl

Overview:
- Word-serial multi-precision adder controller.
- Sequences one WIDTH-bit add datapath across operands of 1..MAX_WORDS words, least significant word first, carrying between words in a carry register.
- Sits between an operand stream source and a result stream sink, with valid/ready handshakes on both sides.
- Produces one registered sum word per accepted operand word, plus the final carry-out on the last word.

Parameters:
- WIDTH, 4, bits per operand/sum word.
- MAX_WORDS, 8, maximum words per operation (must be >= 2).
- IDX_W, $clog2(MAX_WORDS), width of the word index.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand word pair valid.
- in_ready  output  1  controller can accept a word pair.
- in_last  input  1  this is the most significant word of the operation.
- a_word  input  WIDTH  operand A word.
- b_word  input  WIDTH  operand B word.
- out_valid  output  1  sum word valid.
- out_ready  input  1  sink accepts the sum word.
- sum_word  output  WIDTH  sum word.
- out_last  output  1  sum word is the last of the operation.
- word_idx  output  IDX_W  index of the current output word within its operation (0 = LSW).
- carry_out  output  1  final carry; meaningful only when out_valid && out_last.
- len_err  output  1  sticky: an operation exceeded MAX_WORDS.

Behaviour:
- Reset (async assert, sync deassert by the source):
  - out_valid=0, sum_word=0, out_last=0, word_idx=0, carry_out=0, len_err=0.
  - Carry register=0, word counter=0, FSM=IDLE.
- Handshakes:
  - Input transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is a single output register, so back-to-back full throughput is allowed.
  - out_valid and all output payloads hold stable while out_valid && !out_ready.
- Latency: 1 cycle from input transfer to out_valid.
- Arithmetic per accepted word:
  - {c_next, s} = a_word + b_word + carry_reg, computed at WIDTH+1 bits.
  - The result is registered into sum_word; word_idx takes the counter value.
  - If the word is not last: carry_reg <= c_next.
  - If the word is last: carry_out <= c_next and carry_reg <= 0.
- FSM:
  - IDLE: no operation in progress; carry_reg=0, counter=0.
    - Accept with in_last=1 -> single-word operation, stay IDLE.
    - Accept with in_last=0 -> BUSY, counter=1.
  - BUSY: operation in progress.
    - Each accepted non-last word increments the counter.
    - Accepted in_last=1 -> IDLE, counter=0.
- Length limit: if a word is accepted in BUSY with counter==MAX_WORDS-1 and in_last=0:
  - Treat it as last: out_last=1, carry_out=c_next, return to IDLE.
  - Set len_err=1. len_err is cleared only by reset.
  - The next input word starts a new operation.
- No input during an operation: carry_reg holds indefinitely; there is no timeout.
- Simultaneous output transfer and input transfer in the same cycle: the new word loads the output register, and out_valid stays 1.
- Output transfer with no input transfer: out_valid <= 0. Payload registers keep their last values.
- Reset mid-operation: the partial operation is discarded, no output is produced, and the FSM returns to IDLE with carry=0.

Optional Feature:
- Macro: MULTIWORD_ADD_CTRL_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled with the first word of each operation (IDLE accept) and held internally for the whole operation.
  - When sub=1: the B operand is bitwise inverted and the initial carry is 1, giving A - B in two's complement.
  - carry_out=1 means no borrow (A >= B, unsigned).
  - sub changes mid-operation are ignored.
- When undefined: no sub port; addition only; initial carry is always 0.

Test Plan:
1. WIDTH=4. Single word, a=0x9, b=0x8, in_last=1 -> sum_word=0x1, out_last=1, carry_out=1, word_idx=0, one cycle after transfer.
2. Two words, A=0xFF, B=0x01 (LSW first: {F,1} then {F,0,last}) -> sum words 0x0, 0x0; carry propagates; final carry_out=1; word_idx 0 then 1.
3. Back-to-back ops with out_ready=1, A=0x3_2 + B=0x1_1 then single 0x7+0x1 -> outputs 0x3, 0x4(last, carry 0), 0x8(last, carry 0). in_ready stays 1 throughout and the carry does not leak between operations.
4. Backpressure: out_ready=0 for 3 cycles after the first sum -> in_ready=0, sum_word/out_valid stable. Releasing out_ready resumes with no loss or duplication.
5. MAX_WORDS=8 with 9 words and no in_last -> 8th word flagged out_last=1, len_err=1. The 9th word starts a new op with word_idx=0 and carry_in=0.
6. Assert rst_n low after 2 of 4 words -> outputs reset, then a fresh single-word op 0x1+0x1 yields 0x2, carry_out=0. With MULTIWORD_ADD_CTRL_SUB_EN: sub=1, 0x3-0x5 -> 0xE, carry_out=0.
